// File: rtl/la_wb_pkg.sv
// la_wb_pkg: shared types and constants for the LA-side Wishbone master.
//   state_e          - master FSM states (IDLE / BUS / RESP)
//   DEFAULT_TIMEOUT  - default bound on strobe cycles awaiting ack
//   WB_DW / WB_AW    - Wishbone data / address widths
package la_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned WB_DW           = 32;
    localparam int unsigned WB_AW           = 32;
    localparam int unsigned WB_SW           = WB_DW / 8;
    localparam int unsigned CTR_W           = 16;

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: clearable up-counter that flags the last permitted wait cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : load zero (takes priority over en_i)
//   en_i       : increment by one
//   tc_o       : high while the count equals TIMEOUT-1
module wb_timeout_ctr
    import la_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/la_wb_master.sv
// la_wb_master: turns one valid/ready command into one Wishbone classic cycle,
// bounds it with a timeout, and returns read data/status on a valid/ready port.
//   wb_clk_i, wb_rst_ni              : clock, asynchronous active-low reset
//   cmd_valid/ready, we/sel/adr/dat  : command port (accepted when valid & ready)
//   rsp_valid/ready, rsp_dat, rsp_err: response port (err = cycle timed out)
//   wbm_*                            : Wishbone master signals
//   busy_o                           : transfer or response outstanding
//   err_cnt_o                        : saturating count of timeouts since reset
module la_wb_master
    import la_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_SW-1:0]    cmd_sel_i,
    input  logic [WB_AW-1:0]    cmd_adr_i,
    input  logic [WB_DW-1:0]    cmd_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DW-1:0]    rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SW-1:0]    wbm_sel_o,
    output logic [WB_AW-1:0]    wbm_adr_o,
    output logic [WB_DW-1:0]    wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DW-1:0]    wbm_dat_i,
    output logic                busy_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    state_e              state_q,     state_d;
    logic                cyc_q,       cyc_d;
    logic                we_q,        we_d;
    logic [WB_SW-1:0]    sel_q,       sel_d;
    logic [WB_AW-1:0]    adr_q,       adr_d;
    logic [WB_DW-1:0]    wdat_q,      wdat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0]    rsp_dat_q,   rsp_dat_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [ERRCNT_W-1:0] err_cnt_q,   err_cnt_d;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_tc;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (ctr_tc)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    wdat_d  = cmd_dat_i;
                    cyc_d   = 1'b1;
                    ctr_clr = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack is checked first so that an ack on the final permitted
                // cycle still completes normally.
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = ST_RESP;
                end else if (ctr_tc) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                    end
                    state_d     = ST_RESP;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Single-transfer master: cyc and stb are always identical.
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = wdat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_cnt_o   = err_cnt_q;
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_la_wb_master.sv
module tb_la_wb_master;

    localparam int TO  = 4;
    localparam int ECW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_we = 1'b0;
    logic [3:0]     cmd_sel = 4'h0;
    logic [31:0]    cmd_adr = 32'h0;
    logic [31:0]    cmd_dat = 32'h0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [31:0]    rsp_dat;
    logic           rsp_err;
    logic           wbm_cyc, wbm_stb, wbm_we;
    logic [3:0]     wbm_sel;
    logic [31:0]    wbm_adr, wbm_dat;
    logic           wbm_ack = 1'b0;
    logic [31:0]    wbm_dat_in = 32'h0;
    logic           busy;
    logic [ECW-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    la_wb_master #(.TIMEOUT(TO), .ERRCNT_W(ECW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_sel_i   (cmd_sel),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_stb_o   (wbm_stb),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_adr_o   (wbm_adr),
        .wbm_dat_o   (wbm_dat),
        .wbm_ack_i   (wbm_ack),
        .wbm_dat_i   (wbm_dat_in),
        .busy_o      (busy),
        .err_cnt_o   (err_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = waiting for a command, 1 = Wishbone
    // cycle in progress, 2 = response held.  Strobe cycles are counted and the
    // cycle gives up once TO of them have passed without an ack.
    int          m_phase = 0;
    int          m_strobes = 0;
    int          m_errs = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_sel = 4'h0;
    logic [31:0] m_adr = 32'h0;
    logic [31:0] m_dat = 32'h0;
    logic [31:0] m_rdat = 32'h0;
    logic        m_rerr = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   <= 0;
            m_strobes <= 0;
            m_errs    <= 0;
            m_we      <= 1'b0;
            m_sel     <= 4'h0;
            m_adr     <= 32'h0;
            m_dat     <= 32'h0;
            m_rdat    <= 32'h0;
            m_rerr    <= 1'b0;
        end else begin
            if (m_phase == 0) begin
                if (cmd_valid) begin
                    m_we      <= cmd_we;
                    m_sel     <= cmd_sel;
                    m_adr     <= cmd_adr;
                    m_dat     <= cmd_dat;
                    m_strobes <= 0;
                    m_phase   <= 1;
                end
            end else if (m_phase == 1) begin
                if (wbm_ack) begin
                    m_rdat  <= m_we ? 32'h0 : wbm_dat_in;
                    m_rerr  <= 1'b0;
                    m_phase <= 2;
                end else if (m_strobes + 1 == TO) begin
                    m_rdat  <= 32'h0;
                    m_rerr  <= 1'b1;
                    m_errs  <= (m_errs < 255) ? m_errs + 1 : 255;
                    m_phase <= 2;
                end else begin
                    m_strobes <= m_strobes + 1;
                end
            end else begin
                if (rsp_ready) m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_phase == 0});
        chk("busy",      {31'b0, busy},      {31'b0, m_phase != 0});
        chk("cyc",       {31'b0, wbm_cyc},   {31'b0, m_phase == 1});
        chk("stb",       {31'b0, wbm_stb},   {31'b0, m_phase == 1});
        chk("wbm_we",    {31'b0, wbm_we},    {31'b0, m_we});
        chk("wbm_sel",   {28'b0, wbm_sel},   {28'b0, m_sel});
        chk("wbm_adr",   wbm_adr,            m_adr);
        chk("wbm_dat",   wbm_dat,            m_dat);
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_phase == 2});
        if (m_phase == 2) begin
            chk("rsp_dat", rsp_dat,            m_rdat);
            chk("rsp_err", {31'b0, rsp_err},   {31'b0, m_rerr});
        end
        chk("err_cnt",   {24'b0, err_cnt},   32'(m_errs));
    end

    // Issue one command at a negedge in IDLE; slave acks on strobe cycle
    // ack_on (0 = never).  Returns with the response held, at a negedge.
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int ack_on, input logic [31:0] rdata,
                          output int stb_n, output logic [31:0] bus_dat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_dat   = dat;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_sel   = 4'h0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        bus_dat   = wbm_dat;
        stb_n     = 0;
        while (wbm_stb === 1'b1 && stb_n < 100) begin
            stb_n++;
            if (stb_n == ack_on) begin
                wbm_ack    = 1'b1;
                wbm_dat_in = rdata;
            end
            @(posedge clk);
            @(negedge clk);
            wbm_ack    = 1'b0;
            wbm_dat_in = $urandom;
        end
        if (stb_n >= 100) chk("stb_bound", 32'(stb_n), 32'd99);
        chk("txn_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        $display("txn we=%0d adr=%h wdat=%h stb_cycles=%0d rsp_dat=%h err=%0d err_cnt=%0d",
                 we, adr, dat, stb_n, rsp_dat, rsp_err, err_cnt);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          cnt;
        logic [31:0] bd;

        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_stb",       {31'b0, wbm_stb},   32'd0);
        chk("reset_err_cnt",   {24'b0, err_cnt},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, ack on 2nd strobe cycle.
        do_txn(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0001, 2, 32'hDEAD_BEEF, n, bd);
        chk("wr_stb_cycles", 32'(n), 32'd2);
        chk("wr_bus_dat",    bd, 32'hA5A5_0001);
        chk("wr_rsp_dat",    rsp_dat, 32'h0);
        chk("wr_rsp_err",    {31'b0, rsp_err}, 32'd0);
        consume();

        // Read, ack on first strobe cycle.
        do_txn(1'b0, 4'hF, 32'h3000_0010, 32'h0, 1, 32'h1234_5678, n, bd);
        chk("rd_stb_cycles", 32'(n), 32'd1);
        chk("rd_rsp_dat",    rsp_dat, 32'h1234_5678);
        chk("rd_rsp_err",    {31'b0, rsp_err}, 32'd0);
        consume();

        // Timeout, slave never acks.
        do_txn(1'b0, 4'h3, 32'h3000_0020, 32'h0, 0, 32'h0, n, bd);
        chk("to_stb_cycles", 32'(n), 32'd4);
        chk("to_rsp_err",    {31'b0, rsp_err}, 32'd1);
        chk("to_rsp_dat",    rsp_dat, 32'h0);
        chk("to_err_cnt",    {24'b0, err_cnt}, 32'd1);
        consume();

        // Ack on the last permitted cycle wins over timeout.
        do_txn(1'b0, 4'hF, 32'h3000_0024, 32'h0, 4, 32'hCAFE_F00D, n, bd);
        chk("late_stb_cycles", 32'(n), 32'd4);
        chk("late_rsp_err",    {31'b0, rsp_err}, 32'd0);
        chk("late_rsp_dat",    rsp_dat, 32'hCAFE_F00D);
        chk("late_err_cnt",    {24'b0, err_cnt}, 32'd1);
        consume();

        // Saturation of the timeout counter.
        for (int i = 0; i < 300; i++) begin
            do_txn(1'b1, 4'h1, 32'h3000_1000 + 32'(i), 32'(i), 0, 32'h0, n, bd);
            consume();
        end
        chk("sat_err_cnt", {24'b0, err_cnt}, 32'd255);

        // Response backpressure with a pending command.
        do_txn(1'b0, 4'hF, 32'h3000_0030, 32'h0, 1, 32'h5A5A_1234, n, bd);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_sel   = 4'hC;
        cmd_adr   = 32'h3000_0040;
        cmd_dat   = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("bp_cyc",       {31'b0, wbm_cyc},   32'd0);
            chk("bp_rsp_dat",   rsp_dat,            32'h5A5A_1234);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_cyc", {31'b0, wbm_cyc}, 32'd1);
        chk("bp_next_adr", wbm_adr, 32'h3000_0040);
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        wbm_ack = 1'b0;
        chk("bp_next_rsp", rsp_dat, 32'h0BAD_F00D);
        consume();

        // Back-to-back: zero-wait slave, response always consumed.
        cmd_valid  = 1'b1;
        cmd_we     = 1'b0;
        cmd_sel    = 4'hF;
        cmd_adr    = 32'h3000_0050;
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'h7777_0000;
        rsp_ready  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        cmd_valid = 1'b0;
        wbm_ack   = 1'b0;
        rsp_ready = 1'b0;
        chk("b2b_responses", 32'(cnt), 32'd3);
        $display("txn back-to-back reads adr=30000050 responses=%0d", cnt);

        // Asynchronous reset during a bus cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h3000_0060;
        cmd_dat   = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_pre_cyc", {31'b0, wbm_cyc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cyc",       {31'b0, wbm_cyc},   32'd0);
        chk("rst_async_stb",       {31'b0, wbm_stb},   32'd0);
        chk("rst_async_adr",       wbm_adr,            32'h0);
        chk("rst_async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_async_ready",     {31'b0, cmd_ready}, 32'd1);
        chk("rst_async_err_cnt",   {24'b0, err_cnt},   32'd0);
        $display("txn reset during bus cycle adr=30000060");
        @(negedge clk);
        rst_n = 1'b1;
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("spur_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("spur_ready",     {31'b0, cmd_ready}, 32'd1);
        end
        wbm_ack = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/la_wb_master.md
# la_wb_master

Wishbone classic single-transfer master that lets the logic-analyzer (LA) or test harness side issue register reads and writes into `crossbar_wrapper` without the management SoC bus. It sits in `user_analog_project_wrapper` beside `crossbar_wrapper`, converts a valid/ready command into one Wishbone cycle, bounds every cycle with a timeout, and returns read data and status through a valid/ready response port.

## Interface
- `TIMEOUT`, 255: max cycles `wbm_stb_o` stays high awaiting ack; legal range 1..65535.
- `ERRCNT_W`, 8: width of saturating timeout counter.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command accepted when both high at rising edge.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_sel_i`  in  4  byte selects.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `rsp_valid_o`  out  1  response held.
- `rsp_ready_i`  in  1  response consumed when both high at rising edge.
- `rsp_dat_o`  out  32  read data; 0 for writes and timeouts.
- `rsp_err_o`  out  1  1 = cycle timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone strobes.
- `wbm_sel_o`  out  4; `wbm_adr_o`  out  32; `wbm_dat_o`  out  32.
- `wbm_ack_i`  in  1; `wbm_dat_i`  in  32.
- `busy_o`  out  1  high in BUS or RESP.
- `err_cnt_o`  out  `ERRCNT_W`  timeouts since reset, saturating at all-ones.

## Operation
- FSM states IDLE, BUS, RESP; reset to IDLE.
- IDLE: `cmd_ready_o`=1 (combinational from state). On accept: latch we/sel/adr/dat into Wishbone output registers, clear wait counter, go BUS.
- BUS: `wbm_cyc_o`=`wbm_stb_o`=1, address/data/sel/we stable for whole state. Each cycle without ack increments wait counter.
  - `wbm_ack_i`=1: capture `wbm_dat_i` into `rsp_dat_o` if read, else 0; `rsp_err_o`=0; go RESP.
  - No ack and counter == `TIMEOUT`-1: `rsp_dat_o`=0, `rsp_err_o`=1, `err_cnt_o`+1 (saturating), go RESP.
  - Ack in same cycle as timeout: ack wins, no error.
- RESP: `rsp_valid_o`=1, response fields frozen; `cmd_ready_o`=0. On `rsp_ready_i` go IDLE.
- `wbm_ack_i` outside BUS ignored (no state change, no data capture).
- Command fields sampled only at accept; changes after accept have no effect.
- Reset asserted mid-cycle: all outputs return to reset values immediately (asynchronously), in-flight transfer dropped, no response produced.

## Timing
- Reset values: `cmd_ready_o`=1, every other output 0 (incl. `wbm_*`, `rsp_*`, `busy_o`, `err_cnt_o`).
- Accept at edge E0 → `wbm_cyc_o`/`wbm_stb_o` high after E0.
- Ack sampled at edge Ek → strobes low and `rsp_valid_o` high after Ek; one-cycle strobe pulse if ack at E1.
- Minimum command-to-next-accept: 3 edges (accept, ack, rsp consume) with zero-wait slave and `rsp_ready_i` held high.
- Timeout: strobes high for exactly `TIMEOUT` cycles, then `rsp_valid_o` with `rsp_err_o`=1.
- All outputs registered except `cmd_ready_o` and `busy_o` (decoded from state register).

## Structure
- Package `la_wb_pkg`: state enum (IDLE/BUS/RESP), default `TIMEOUT`, Wishbone data/address width constants.
- Sub-module `wb_timeout_ctr`: clearable up-counter with terminal-count flag at `TIMEOUT`-1; instantiated once.
- Saturating error counter and FSM stay in top level.

## Test plan
- Write 0xA5A5_0001 to 0x3000_0004, sel=0xF, slave acks at 2nd stb cycle → stb high 2 cycles, `wbm_dat_o`=0xA5A5_0001, response err=0 dat=0.
- Read 0x3000_0010, slave returns 0x1234_5678 with ack on first stb cycle → `rsp_dat_o`=0x1234_5678, err=0, strobes one cycle.
- `TIMEOUT`=4, slave never acks → stb high exactly 4 cycles, `rsp_err_o`=1, `rsp_dat_o`=0, `err_cnt_o`=1; 300 more timeouts with `ERRCNT_W`=8 → `err_cnt_o`=255.
- `TIMEOUT`=4, ack on 4th stb cycle → err=0, read data captured, `err_cnt_o` unchanged.
- `rsp_ready_i` held low 10 cycles, `cmd_valid_i` high → response fields stable, `cmd_ready_o`=0, no new cycle; release → IDLE next edge, next command accepted.
- Assert `wb_rst_ni` low during BUS → strobes drop with no clock edge, no response; after release, spurious `wbm_ack_i` in IDLE ignored.
